aluout_trace_buffer: RTL and testbench
======================================

Name: aluout_trace_buffer

Overview:
Captures the processor's 8-bit ALU result stream into an on-chip trace FIFO. The FIFO is drained through a valid/ready read port. In parallel the block keeps a running 8-bit MISR signature and a saturating sample count. It sits beside `processor` and is fed from `aluout`, so results can be checked in silicon and in gate-level/SDF simulation without per-cycle printing.

Parameters:
- DATA_W, 8, width of captured ALU result.
- DEPTH, 8, FIFO entries (power of two).
- ADDR_W, 3, log2(DEPTH).
- SIG_POLY, 8'h1D, MISR feedback polynomial.

Ports:
- clk, input, 1, system clock. Single clock domain; all logic on posedge.
- reset, input, 1, system reset. Synchronous, active-high.
- clear, input, 1, synchronous soft clear. Same effect as reset.
- cap_en, input, 1, capture enable.
- in_valid, input, 1, in_data holds a result this cycle.
- in_data, input, DATA_W, ALU result (driven from aluout).
- out_valid, output, 1, FIFO head is valid.
- out_ready, input, 1, consumer accepts the head.
- out_data, output, DATA_W, FIFO head word.
- count, output, ADDR_W+1, current FIFO occupancy (0..DEPTH).
- overflow, output, 1, sticky flag: a sample was dropped because the FIFO was full.
- signature, output, DATA_W, MISR value.
- sample_cnt, output, 16, number of samples offered, saturating.

Behaviour:
- Reset/clear: one cycle of reset or clear sets, at the next edge:
  - rd_ptr = wr_ptr = 0, count = 0;
  - out_valid = 0, out_data = 0;
  - overflow = 0, signature = 0, sample_cnt = 0.
  - reset has priority over clear; clear has priority over any same-cycle push or pop (both discarded).
  - Reset asserted mid-operation discards all buffered data.
- Sample: `sample = in_valid & cap_en`. No sample is taken when cap_en = 0.
- Pop: `pop = out_valid & out_ready`.
- Push: `push = sample & (count != DEPTH | pop)`.
  - Simultaneous push and pop when full is legal: count stays DEPTH and overflow is not set.
- Drop: `sample & count == DEPTH & !pop` drops in_data and sets overflow = 1. overflow stays set until reset/clear.
- Count update per cycle:
  - count +1 on push only;
  - count −1 on pop only;
  - unchanged on both or neither.
- Pointers: wr_ptr/rd_ptr are ADDR_W bits and wrap DEPTH−1 → 0.
- Output is first-word-fall-through:
  - out_valid = (count != 0);
  - out_data = mem[rd_ptr] when out_valid, else 0.
  - Latency: a word pushed into an empty FIFO at edge N is visible on out_data with out_valid = 1 after edge N (one cycle).
- Pop on empty is impossible because out_valid = 0. out_ready is ignored while out_valid = 0.
- out_data must hold stable while out_valid = 1 and out_ready = 0.
- MISR, updated on every sample regardless of FIFO acceptance:
  - `sig_next = {sig[6:0],1'b0} ^ (sig[7] ? SIG_POLY : 0) ^ in_data`.
- sample_cnt increments on every sample and saturates at 16'hFFFF.

Test Plan:
1. Reset, then feed 8'h01, 8'h02, 8'h80, 8'h00 with cap_en = 1 and out_ready = 0 → signature steps 01, 00, 80, 1D; count = 4; sample_cnt = 4; out_data = 8'h01.
2. With out_ready = 0, push values 1..10 → count = 8 after the 8th; overflow = 1 after the 9th; sample_cnt = 10. Then assert out_ready → out_data sequence 1..8, then out_valid = 0 and count = 0.
3. With FIFO full (1..8), present in_data = 8'h55 in the same cycle as out_ready = 1 → count stays 8, overflow stays 0, the 8th subsequent pop returns 8'h55.
4. in_valid = 1 with cap_en = 0 for 5 cycles → count, signature and sample_cnt unchanged.
5. Hold out_ready = 0 for 3 cycles with head 8'hA7 → out_data = 8'hA7 and out_valid = 1 each cycle.
6. Load 5 entries with overflow set, then pulse clear for one cycle together with in_valid = 1 → next cycle count = 0, out_valid = 0, overflow = 0, signature = 0, sample_cnt = 0. Repeat with reset asserted mid-drain → same result.

Source files
------------

// File: rtl/aluout_trace_buffer.sv
// Trace buffer for the ALU result stream: first-word-fall-through FIFO with a
// valid/ready drain port, plus a running MISR signature and a saturating sample count.
module aluout_trace_buffer #(
  parameter int                 DATA_W   = 8,
  parameter int                 DEPTH    = 8,
  parameter int                 ADDR_W   = 3,
  parameter logic [DATA_W-1:0]  SIG_POLY = 8'h1D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              cap_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [DATA_W-1:0] signature,
  output logic [15:0]       sample_cnt
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic [15:0]       sample_cnt_q, sample_cnt_d;

  logic sample, pop, push, drop, full, wr_en;

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise an
    // untaken branch leaves it holding its old value and a latch is inferred.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    sig_d        = sig_q;
    sample_cnt_d = sample_cnt_q;

    full   = (count_q == FULL_CNT);
    sample = in_valid & cap_en;
    pop    = (count_q != '0) & out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    push   = sample & (~full | pop);
    drop   = sample & full & ~pop;
    wr_en  = push & ~clear & ~reset;

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      sig_d        = '0;
      sample_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (drop) overflow_d = 1'b1;

      // The signature folds in every offered sample, accepted or dropped.
      if (sample) begin
        sig_d = {sig_q[DATA_W-2:0], 1'b0}
              ^ (sig_q[DATA_W-1] ? SIG_POLY : '0)
              ^ in_data;
        if (sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      sig_q        <= '0;
      sample_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      sig_q        <= sig_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // once written, and leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign signature  = sig_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_aluout_trace_buffer.sv
// Self-checking bench for aluout_trace_buffer: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_aluout_trace_buffer;

  logic       clk = 1'b0;
  logic       reset, clear, cap_en, in_valid, out_ready;
  logic [7:0] in_data;
  logic       out_valid, overflow;
  logic [7:0] out_data, signature;
  logic [3:0] count;
  logic [15:0] sample_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int q[$];
  int m_sig;
  bit m_ovf;
  int m_scnt;

  always #5 clk = ~clk;

  aluout_trace_buffer dut (
    .clk(clk), .reset(reset), .clear(clear), .cap_en(cap_en),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count),
    .overflow(overflow), .signature(signature), .sample_cnt(sample_cnt)
  );

  // Applies one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic cycle(input bit rst, input bit clr, input bit iv, input bit ce,
                       input bit rdy, input logic [7:0] d);
    bit smp, pp;
    reset = rst; clear = clr; in_valid = iv; cap_en = ce; out_ready = rdy; in_data = d;
    if (rst || clr) begin
      q.delete(); m_sig = 0; m_ovf = 0; m_scnt = 0;
    end else begin
      smp = iv && ce;
      pp  = rdy && (q.size() != 0);
      if (smp) begin
        if (q.size() < 8 || pp) q.push_back(int'(d));
        else m_ovf = 1;
        m_sig = ((m_sig * 2) % 256) ^ ((m_sig >= 128) ? 'h1D : 0) ^ int'(d);
        if (m_scnt < 65535) m_scnt++;
      end
      if (pp) void'(q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  function automatic int m_head();
    return (q.size() != 0) ? q[0] : 0;
  endfunction

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 8'h00);
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", out_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_cmp++; if (signature !== 8'h00) begin n_err++; $display("FAIL reset_sig got=%h exp=00", signature); end
    n_cmp++; if (sample_cnt !== 16'd0) begin n_err++; $display("FAIL reset_scnt got=%0d exp=0", sample_cnt); end
  endtask

  task automatic test_signature();
    logic [7:0] din [4] = '{8'h01, 8'h02, 8'h80, 8'h00};
    logic [7:0] exp [4] = '{8'h01, 8'h00, 8'h80, 8'h1D};
    cycle(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 1, 0, din[i]);
      n_cmp++; if (signature !== exp[i]) begin n_err++; $display("FAIL sig_step%0d got=%h exp=%h", i, signature, exp[i]); end
    end
    n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL sig_count got=%0d exp=4", count); end
    n_cmp++; if (sample_cnt !== 16'd4) begin n_err++; $display("FAIL sig_scnt got=%0d exp=4", sample_cnt); end
    n_cmp++; if (out_data !== 8'h01) begin n_err++; $display("FAIL sig_head got=%h exp=01", out_data); end
  endtask

  task automatic test_overflow();
    cycle(1, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 0, 1, 1, 0, 8'(i));
      if (i == 8) begin
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_full_count got=%0d exp=8", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
      if (i == 9) begin
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      end
    end
    n_cmp++; if (sample_cnt !== 16'd10) begin n_err++; $display("FAIL ovf_scnt got=%0d exp=10", sample_cnt); end
    for (int i = 1; i <= 8; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        n_err++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 8'(i));
      end
      cycle(0, 0, 0, 1, 1, 8'h00);
    end
    n_cmp++; if (out_valid !== 1'b0 || count !== 4'd0) begin
      n_err++; $display("FAIL ovf_empty got=%b/%0d exp=0/0", out_valid, count);
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    cycle(1, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, 1, 0, 8'(i));
    cycle(0, 0, 1, 1, 1, 8'h55);
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fpp_count got=%0d exp=8", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        n_cmp++; if (out_data !== 8'h55) begin n_err++; $display("FAIL fpp_last got=%h exp=55", out_data); end
      end else begin
        n_cmp++; if (out_data !== 8'(i + 1)) begin n_err++; $display("FAIL fpp_pop%0d got=%h exp=%h", i, out_data, 8'(i + 1)); end
      end
      cycle(0, 0, 0, 1, 1, 8'h00);
    end
  endtask

  task automatic test_cap_disable();
    logic [7:0] s0 = signature;
    logic [3:0] c0 = count;
    logic [15:0] n0 = sample_cnt;
    cycle(0, 0, 1, 1, 0, 8'h3C);
    s0 = signature; c0 = count; n0 = sample_cnt;
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, 8'($urandom));
    n_cmp++; if (count !== c0) begin n_err++; $display("FAIL capdis_count got=%0d exp=%0d", count, c0); end
    n_cmp++; if (signature !== s0) begin n_err++; $display("FAIL capdis_sig got=%h exp=%h", signature, s0); end
    n_cmp++; if (sample_cnt !== n0) begin n_err++; $display("FAIL capdis_scnt got=%0d exp=%0d", sample_cnt, n0); end
  endtask

  task automatic test_hold();
    cycle(1, 0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 1, 0, 8'hA7);
    cycle(0, 0, 1, 1, 0, 8'h11);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA7) begin
        n_err++; $display("FAIL hold%0d got=%b/%h exp=1/a7", i, out_valid, out_data);
      end
      cycle(0, 0, 0, 1, 0, 8'h00);
    end
  endtask

  task automatic check_cleared(input string tag);
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_err++; $display("FAIL %s_fifo got=%0d/%b/%h exp=0/0/00", tag, count, out_valid, out_data);
    end
    n_cmp++; if (overflow !== 1'b0 || signature !== 8'h00 || sample_cnt !== 16'd0) begin
      n_err++; $display("FAIL %s_stat got=%b/%h/%0d exp=0/00/0", tag, overflow, signature, sample_cnt);
    end
  endtask

  task automatic test_clear();
    cycle(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 1, 0, 8'($urandom));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 8'h00);
    n_cmp++; if (count !== 4'd5 || overflow !== 1'b1) begin
      n_err++; $display("FAIL clr_pre got=%0d/%b exp=5/1", count, overflow);
    end
    cycle(0, 1, 1, 1, 1, 8'hEE);
    check_cleared("clr");
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 1, 0, 8'($urandom));
    cycle(0, 0, 1, 1, 1, 8'h42);
    cycle(1, 0, 1, 1, 1, 8'h43);
    check_cleared("rst_mid");
    cycle(0, 0, 1, 1, 0, 8'h99);
    n_cmp++; if (out_data !== 8'h99 || count !== 4'd1) begin
      n_err++; $display("FAIL post_rst got=%h/%0d exp=99/1", out_data, count);
    end
  endtask

  task automatic test_random();
    bit rst, clr, iv, ce, rdy;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 59) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      ce  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 2) == 0) || (n % 100 > 70);
      cycle(rst, clr, iv, ce, rdy, 8'($urandom));
      n_cmp++;
      if (count !== 4'(q.size()) || out_valid !== (q.size() != 0) || out_data !== 8'(m_head()) ||
          overflow !== m_ovf || signature !== 8'(m_sig) || sample_cnt !== 16'(m_scnt)) begin
        n_err++;
        $display("FAIL rand%0d got=cnt%0d v%b d%h o%b s%h n%0d exp=cnt%0d v%b d%h o%b s%h n%0d",
                 n, count, out_valid, out_data, overflow, signature, sample_cnt,
                 q.size(), q.size() != 0, 8'(m_head()), m_ovf, 8'(m_sig), m_scnt);
      end
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; cap_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    m_sig = 0; m_ovf = 0; m_scnt = 0;
    test_reset();
    test_signature();
    test_overflow();
    test_full_push_pop();
    test_cap_disable();
    test_hold();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
